sync_to_axis_packer: RTL and testbench
======================================

// Module: sync_to_axis_packer
// PURPOSE
//  Consumer end of the pixel sync stream (H_SYNC/V_SYNC/data_en/8-bit pixel) produced by the FAST pipeline.
//  Repacks the stream into an AXI4-Stream master: TUSER marks start-of-frame, TLAST marks end-of-line.
//  An internal FWFT FIFO absorbs TREADY backpressure. The source cannot stall, so beats arriving while the FIFO is full are dropped and flagged.
// PARAMETERS
//  DATA_WIDTH   8   pixel width
//  ADDR_WIDTH   4   FIFO address bits; depth = 2**ADDR_WIDTH (16)
// PORTS
//  clk          in   1             single clock, rising edge
//  rst          in   1             asynchronous, active-high reset
//  in_H_SYNC    in   1             line sync; rising edge realigns column counter
//  in_V_SYNC    in   1             frame sync; rising edge starts a frame
//  in_data_en   in   1             pixel valid; source cannot stall
//  data_in      in   DATA_WIDTH    pixel
//  width_in     in   11            active pixels per line, latched at V_SYNC rise
//  height_in    in   11            active lines per frame, latched at V_SYNC rise
//  TDATA        out  DATA_WIDTH    FIFO head pixel
//  TVALID       out  1             FIFO not empty
//  TREADY       in   1             downstream accept
//  TLAST        out  1             head beat is last pixel of a line
//  TUSER        out  1             head beat is first pixel of a frame
//  overflow     out  1             sticky: at least one input beat dropped
//  fifo_level   out  ADDR_WIDTH+1  FIFO occupancy, 0..2**ADDR_WIDTH
//  frame_done   out  1             1-cycle pulse when the last pixel of a frame is pushed
// BEHAVIOUR
//  Reset (async, rst=1): FIFO empty; col/row counters 0; width/height regs 0; sof_pending 0.
//   All outputs read 0: TVALID, TDATA, TLAST, TUSER, overflow, fifo_level, frame_done.
//  Edge detect: in_V_SYNC and in_H_SYNC are registered each cycle; rise = cur & ~prev.
//  On a V_SYNC rise:
//   - latch width_in/height_in; col_cnt<=0; row_cnt<=0; sof_pending<=1.
//   - The FIFO is NOT flushed, and overflow is NOT cleared.
//  On an H_SYNC rise (no V_SYNC rise in the same cycle): col_cnt<=0; row_cnt unchanged.
//  Input beat (in_data_en=1):
//   - entry = {data_in, sof=sof_pending, eol=(col_cnt==width-1)}.
//   - sof_pending clears on any input beat, whether pushed or dropped.
//   - eol: col_cnt wraps to 0 and row_cnt increments; row_cnt wraps to 0 after height-1.
//   - frame_done pulses in the cycle after a beat with eol=1 and row_cnt==height-1, if that beat was pushed.
//   - width==0: eol is never set and col_cnt free-runs mod 2048. height==0: frame_done never fires.
//   - A beat coinciding with a sync rise uses the post-reset counters (col 0, sof=1 for V).
//  Push/pop:
//   - pop = TVALID & TREADY.
//   - push = in_data_en & (~full | pop): when full, a beat is accepted if a pop occurs in the same cycle.
//   - Otherwise the beat is dropped and overflow<=1; overflow clears only on rst.
//   - Counters advance on dropped beats too, so framing stays aligned.
//  Latency: a beat pushed at edge N is visible on TVALID/TDATA/TLAST/TUSER after edge N. Input-to-output is 1 cycle when the FIFO is empty.
//  AXI rules:
//   - TDATA/TLAST/TUSER stay stable while TVALID=1 and TREADY=0.
//   - TVALID never drops without a pop.
//   - Empty FIFO: TVALID=0 and TDATA/TLAST/TUSER are forced to 0.
//  fifo_level: updated at the same edge as push/pop; push&pop together leave it unchanged.
//  Pointers are ADDR_WIDTH+1 bits with MSB wrap:
//   - full = (wr^rd)==2**ADDR_WIDTH.
//   - empty = wr==rd.
//  A mid-frame rst discards FIFO contents. The next frame begins only at the next V_SYNC rise; beats arriving before that are pushed with sof=0.
// TESTING
//  1) width=4, height=2, TREADY=1, 8 pixels 0x10..0x17 after a V_SYNC pulse:
//     8 beats, 1-cycle latency; TUSER on 0x10 only; TLAST on 0x13 and 0x17; frame_done once; overflow=0.
//  2) TREADY=0, 20 consecutive beats:
//     fifo_level=16, overflow=1; then TREADY=1 drains exactly the first 16 pixels in order.
//  3) FIFO full, TREADY=1 and in_data_en=1 in the same cycle: beat accepted, fifo_level stays 16, overflow stays 0.
//  4) width_in changed 4->6 mid-frame: TLAST stays every 4th pixel until the next V_SYNC rise, then every 6th.
//  5) H_SYNC rise after 2 of 4 pixels: next pixel has col=0; TLAST lands on the 4th pixel after the realign.
//  6) rst asserted with 5 beats queued: all outputs 0 immediately (async); after release, no TUSER until a new V_SYNC rise.

Source files
------------

// File: rtl/sync_to_axis_packer.sv
// Repacks the FAST pipeline pixel sync stream into an AXI4-Stream master.
// A first-word-fall-through FIFO absorbs TREADY backpressure.
module sync_to_axis_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_H_SYNC,
    input  logic                  in_V_SYNC,
    input  logic                  in_data_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [10:0]           width_in,
    input  logic [10:0]           height_in,
    output logic [DATA_WIDTH-1:0] TDATA,
    output logic                  TVALID,
    input  logic                  TREADY,
    output logic                  TLAST,
    output logic                  TUSER,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   fifo_level,
    output logic                  frame_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sof;
        logic                  eol;
    } entry_t;

    entry_t              mem_q [DEPTH];
    entry_t              wr_entry;
    entry_t              head;

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic                vs_q, hs_q;
    logic [10:0]         width_q, width_d;
    logic [10:0]         height_q, height_d;
    logic [10:0]         col_q, col_d;
    logic [10:0]         row_q, row_d;
    logic                sof_pending_q, sof_pending_d;
    logic                overflow_q, overflow_d;
    logic                frame_done_q, frame_done_d;

    logic                v_rise, h_rise;
    logic                full, empty, push, pop;
    logic [10:0]         col_eff, row_eff, width_eff, height_eff;
    logic                sof_eff, eol, last_row;

    assign v_rise = in_V_SYNC & ~vs_q;
    assign h_rise = in_H_SYNC & ~hs_q;
    assign full   = (wr_ptr_q ^ rd_ptr_q) == {1'b1, {ADDR_WIDTH{1'b0}}};
    assign empty  = wr_ptr_q == rd_ptr_q;
    assign pop    = ~empty & TREADY;
    assign push   = in_data_en & (~full | pop);

    // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        width_d       = width_q;
        height_d      = height_q;
        col_d         = col_q;
        row_d         = row_q;
        sof_pending_d = sof_pending_q;
        overflow_d    = overflow_q;
        frame_done_d  = 1'b0;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        col_eff       = col_q;
        row_eff       = row_q;
        width_eff     = width_q;
        height_eff    = height_q;
        sof_eff       = sof_pending_q;

        // A sync rise resets the counters before a coinciding beat is framed.
        if (v_rise) begin
            width_eff  = width_in;
            height_eff = height_in;
            col_eff    = '0;
            row_eff    = '0;
            sof_eff    = 1'b1;
        end else if (h_rise) begin
            col_eff    = '0;
        end

        eol      = (width_eff != '0) && (col_eff == width_eff - 11'd1);
        last_row = (height_eff != '0) && (row_eff == height_eff - 11'd1);
        wr_entry = '{data: data_in, sof: sof_eff, eol: eol};

        width_d       = width_eff;
        height_d      = height_eff;
        col_d         = col_eff;
        row_d         = row_eff;
        sof_pending_d = sof_eff;

        // Counters advance on dropped beats too, keeping framing aligned.
        if (in_data_en) begin
            sof_pending_d = 1'b0;
            if (eol) begin
                col_d        = '0;
                row_d        = last_row ? 11'd0 : row_eff + 11'd1;
                frame_done_d = push & last_row;
            end else begin
                col_d = col_eff + 11'd1;
            end
            if (!push) overflow_d = 1'b1;
        end

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q          <= 1'b0;
            hs_q          <= 1'b0;
            width_q       <= '0;
            height_q      <= '0;
            col_q         <= '0;
            row_q         <= '0;
            sof_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
            frame_done_q  <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            vs_q          <= in_V_SYNC;
            hs_q          <= in_H_SYNC;
            width_q       <= width_d;
            height_q      <= height_d;
            col_q         <= col_d;
            row_q         <= row_d;
            sof_pending_q <= sof_pending_d;
            overflow_q    <= overflow_d;
            frame_done_q  <= frame_done_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // NOTE: storage is left unreset; equal pointers mark it empty and outputs are masked to 0.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_entry;
    end

    assign head       = mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
    assign TVALID     = ~empty;
    assign TDATA      = empty ? '0 : head.data;
    assign TUSER      = ~empty & head.sof;
    assign TLAST      = ~empty & head.eol;
    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sync_to_axis_packer.sv
// Directed and randomized bench for sync_to_axis_packer, checked against a
// queue-based reference model of the framing and FIFO rules.
module tb_sync_to_axis_packer;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_H_SYNC, in_V_SYNC, in_data_en, TREADY;
    logic [7:0]  data_in;
    logic [10:0] width_in, height_in;
    logic [7:0]  TDATA;
    logic        TVALID, TLAST, TUSER, overflow, frame_done;
    logic [4:0]  fifo_level;

    int checks = 0;
    int errors = 0;
    int fd_count;

    sync_to_axis_packer #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .in_H_SYNC(in_H_SYNC), .in_V_SYNC(in_V_SYNC), .in_data_en(in_data_en),
        .data_in(data_in), .width_in(width_in), .height_in(height_in),
        .TDATA(TDATA), .TVALID(TVALID), .TREADY(TREADY), .TLAST(TLAST), .TUSER(TUSER),
        .overflow(overflow), .fifo_level(fifo_level), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: frame position as plain integers, FIFO as a queue of beats.
    typedef struct {
        int data;
        bit sof;
        bit eol;
    } beat_t;

    beat_t m_q[$];
    int    m_w, m_h, m_col, m_row;
    bit    m_sof, m_ovf, m_fd, m_vs_prev, m_hs_prev;

    function automatic void model_reset();
        m_q.delete();
        m_w = 0; m_h = 0; m_col = 0; m_row = 0;
        m_sof = 0; m_ovf = 0; m_fd = 0; m_vs_prev = 0; m_hs_prev = 0;
    endfunction

    function automatic void model_step();
        bit    do_pop, do_push;
        beat_t b;
        if (in_V_SYNC && !m_vs_prev) begin
            m_w = int'(width_in); m_h = int'(height_in);
            m_col = 0; m_row = 0; m_sof = 1;
        end else if (in_H_SYNC && !m_hs_prev) begin
            m_col = 0;
        end
        do_pop  = (m_q.size() > 0) && TREADY;
        do_push = 0;
        m_fd    = 0;
        if (in_data_en) begin
            b.data  = int'(data_in);
            b.sof   = m_sof;
            b.eol   = (m_w != 0) && (m_col == m_w - 1);
            do_push = (m_q.size() < 16) || do_pop;
            m_sof   = 0;
            if (b.eol) begin
                m_col = 0;
                if (m_h != 0 && m_row == m_h - 1) begin
                    m_row = 0;
                    m_fd  = do_push;
                end else begin
                    m_row = (m_row + 1) % 2048;
                end
            end else begin
                m_col = (m_col + 1) % 2048;
            end
            if (!do_push) m_ovf = 1;
        end
        if (do_pop)  void'(m_q.pop_front());
        if (do_push) m_q.push_back(b);
        m_vs_prev = in_V_SYNC;
        m_hs_prev = in_H_SYNC;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        bit v;
        v = m_q.size() > 0;
        check("tvalid",     32'(TVALID),     32'(v));
        check("tdata",      32'(TDATA),      v ? 32'(m_q[0].data) : 32'd0);
        check("tuser",      32'(TUSER),      v ? 32'(m_q[0].sof)  : 32'd0);
        check("tlast",      32'(TLAST),      v ? 32'(m_q[0].eol)  : 32'd0);
        check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    // One clock: drive inputs, advance the model, sample 1 ns after the edge.
    task automatic step(input logic vs, input logic hs, input logic de,
                        input logic [7:0] d, input logic tr);
        in_V_SYNC = vs; in_H_SYNC = hs; in_data_en = de; data_in = d; TREADY = tr;
        model_step();
        @(posedge clk);
        #1;
        if (frame_done === 1'b1) fd_count++;
        check_all();
    endtask

    task automatic do_reset();
        in_V_SYNC = 0; in_H_SYNC = 0; in_data_en = 0; TREADY = 0;
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all();
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && m_q.size() > 0; i++) step(0, 0, 0, 8'h00, 1);
        check("drain_empty", 32'(TVALID), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        in_V_SYNC = 0; in_H_SYNC = 0; in_data_en = 0; data_in = '0; TREADY = 0;
        width_in = 11'd4; height_in = 11'd2;
        model_reset();
        fd_count = 0;
        @(posedge clk);
        #1;
        check_all();
        rst = 1'b0;

        // 1) 4x2 frame, TREADY=1, pixels 0x10..0x17.
        step(1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 8'(8'h10 + i), 1);
        step(0, 0, 0, 8'h00, 1);
        check("t1_frame_done_count", 32'(fd_count), 32'd1);
        check("t1_overflow", 32'(overflow), 32'd0);

        // 2) TREADY=0, 20 beats: 16 kept, 4 dropped, then drain in order.
        for (int i = 0; i < 20; i++) step(0, 0, 1, 8'($urandom), 0);
        check("t2_level", 32'(fifo_level), 32'd16);
        check("t2_overflow", 32'(overflow), 32'd1);
        drain();

        // 3) Full FIFO, simultaneous push and pop.
        do_reset();
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 8'($urandom), 0);
        step(0, 0, 1, 8'hA5, 1);
        check("t3_level", 32'(fifo_level), 32'd16);
        check("t3_overflow", 32'(overflow), 32'd0);
        drain();

        // 4) width changes mid-frame; new value applies from next V_SYNC rise.
        width_in = 11'd4; height_in = 11'd3;
        step(1, 0, 0, 8'h00, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom), 1'($urandom));
        width_in = 11'd6;
        for (int i = 0; i < 10; i++) step(0, 0, 1, 8'($urandom), 1'($urandom));
        step(1, 0, 1, 8'($urandom), 1'($urandom));
        for (int i = 0; i < 12; i++) step(0, 0, 1, 8'($urandom), 1);
        drain();

        // 5) H_SYNC realign after 2 of 4 pixels.
        width_in = 11'd4; height_in = 11'd2;
        step(1, 0, 0, 8'h00, 1);
        step(0, 0, 1, 8'h50, 1);
        step(0, 0, 1, 8'h51, 1);
        step(0, 1, 0, 8'h00, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 8'(8'h60 + i), 1);
        drain();

        // 6) Async reset with 5 beats queued; no TUSER until a new V_SYNC rise.
        step(1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 8'($urandom), 0);
        check("t6_level_before", 32'(fifo_level), 32'd5);
        #2;
        do_reset();
        for (int i = 0; i < 6; i++) step(0, 0, 1, 8'($urandom), 1);
        step(1, 0, 1, 8'h77, 1);
        step(0, 0, 0, 8'h00, 1);
        drain();

        // Random stream: sparse syncs, random geometry including zero sizes.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 40) == 0) begin
                width_in  = 11'($urandom_range(0, 7));
                height_in = 11'($urandom_range(0, 3));
            end
            step(1'($urandom_range(0, 50) == 0), 1'($urandom_range(0, 10) == 0),
                 1'($urandom_range(0, 9) < 7), 8'($urandom), 1'($urandom_range(0, 9) < 6));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
